branch_tracker: RTL and testbench

Tracks conditional-branch predictions from IF until EX resolves them, in program order. On each resolution it drives the gshare predictor's update port and detects mispredictions. On a mispredict it issues a one-cycle redirect/flush to the front end. It sits between the IF-stage predictor lookup and the EX-stage branch unit, and also keeps saturating branch and mispredict statistics.

---
 rtl/branch_tracker.sv | 124 ++++++++++++
 tb/tb_branch_tracker.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_tracker.sv
// In-order tracker of predicted conditional branches between IF lookup and EX resolve.
// Drives the gshare update port, flags mispredicts with a one-cycle redirect, and keeps statistics.
module branch_tracker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_target_i,
  output logic             full_o,
  input  logic             res_valid_i,
  input  logic             res_taken_i,
  input  logic [31:0]      res_target_i,
  input  logic             flush_i,
  output logic             upd_valid_o,
  output logic             upd_taken_o,
  output logic [9:0]       upd_pc_lsb10_o,
  output logic             mispredict_o,
  output logic [31:0]      redirect_pc_o,
  output logic             res_error_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [31:0]      pc_q   [DEPTH];
  logic             ptk_q  [DEPTH];
  logic [31:0]      ptgt_q [DEPTH];

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW:0]      count_q, count_d;

  logic             upd_valid_q, upd_taken_q, mis_q, err_q;
  logic [9:0]       upd_pc_q;
  logic [31:0]      redir_q;
  logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

  logic [31:0]      head_pc, head_tgt, actual_next;
  logic             head_tk, res_fire, mis_now, enq, pop, res_err;

  assign full_o   = (count_q == FULL_CNT);
  assign head_pc  = pc_q[head_q];
  assign head_tk  = ptk_q[head_q];
  assign head_tgt = ptgt_q[head_q];

  assign res_fire    = res_valid_i && (count_q != '0) && !flush_i;
  assign res_err     = res_valid_i && (count_q == '0) && !flush_i;
  assign actual_next = res_taken_i ? res_target_i : head_pc + 32'd4;
  assign mis_now     = res_fire && ((res_taken_i != head_tk) ||
                                    (res_taken_i && (head_tgt != res_target_i)));
  // A drop while full holds even when a pop frees a slot this same cycle.
  assign enq = pred_valid_i && !full_o && !flush_i && !mis_now;
  assign pop = res_fire && !mis_now;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;
    if (flush_i || mis_now) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PW'(1);
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + (PW+1)'(enq) - (PW+1)'(pop);
    end
    if (res_fire && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_W'(1);
    if (mis_now && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_q[tail_q]   <= pred_pc_i;
      ptk_q[tail_q]  <= pred_taken_i;
      ptgt_q[tail_q] <= pred_target_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      upd_pc_q    <= '0;
      mis_q       <= 1'b0;
      redir_q     <= '0;
      err_q       <= 1'b0;
      bcnt_q      <= '0;
      mcnt_q      <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      upd_valid_q <= res_fire;
      upd_taken_q <= res_fire & res_taken_i;
      upd_pc_q    <= res_fire ? head_pc[9:0] : 10'd0;
      mis_q       <= mis_now;
      redir_q     <= mis_now ? actual_next : 32'd0;
      err_q       <= res_err;
      bcnt_q      <= bcnt_d;
      mcnt_q      <= mcnt_d;
    end
  end

  assign upd_valid_o      = upd_valid_q;
  assign upd_taken_o      = upd_taken_q;
  assign upd_pc_lsb10_o   = upd_pc_q;
  assign mispredict_o     = mis_q;
  assign redirect_pc_o    = redir_q;
  assign res_error_o      = err_q;
  assign branch_cnt_o     = bcnt_q;
  assign mispredict_cnt_o = mcnt_q;

endmodule

// File: tb/tb_branch_tracker.sv
// Scoreboard bench for branch_tracker: a reference queue model predicts each cycle's
// registered outputs, which are pushed when stimulus is driven and popped after the edge.
module tb_branch_tracker;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk_i = 1'b0;
  logic          rst_i, pred_valid_i, pred_taken_i, res_valid_i, res_taken_i, flush_i;
  logic [31:0]   pred_pc_i, pred_target_i, res_target_i;
  logic          full_o, upd_valid_o, upd_taken_o, mispredict_o, res_error_o;
  logic [9:0]    upd_pc_lsb10_o;
  logic [31:0]   redirect_pc_o;
  logic [CW-1:0] branch_cnt_o, mispredict_cnt_o;

  branch_tracker #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .full_o(full_o),
    .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
    .flush_i(flush_i),
    .upd_valid_o(upd_valid_o), .upd_taken_o(upd_taken_o), .upd_pc_lsb10_o(upd_pc_lsb10_o),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o), .res_error_o(res_error_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
  } entry_t;

  typedef struct {
    logic        uv, ut, mis, err, full;
    logic [9:0]  upc;
    logic [31:0] redir;
    logic [CW-1:0] bc, mc;
  } exp_t;

  entry_t  mq[$];
  exp_t    exp_q[$];
  logic [CW-1:0] m_bc, m_mc;
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic rs, input logic pv, input logic [31:0] pc,
                      input logic pt, input logic [31:0] ptgt,
                      input logic rv, input logic rt, input logic [31:0] rtgt,
                      input logic fl);
    exp_t   e;
    entry_t h, n;
    logic   was_full, mis;
    rst_i = rs; pred_valid_i = pv; pred_pc_i = pc; pred_taken_i = pt; pred_target_i = ptgt;
    res_valid_i = rv; res_taken_i = rt; res_target_i = rtgt; flush_i = fl;
    e = '{uv:0, ut:0, mis:0, err:0, full:0, upc:0, redir:0, bc:0, mc:0};
    was_full = (mq.size() == DEPTH);
    mis = 1'b0;
    if (rs) begin
      mq.delete(); m_bc = '0; m_mc = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (rv && mq.size() == 0) e.err = 1'b1;
      if (rv && mq.size() > 0) begin
        h = mq[0];
        mis = (rt != h.tk) || (rt && h.tgt != rtgt);
        e.uv = 1'b1; e.ut = rt; e.upc = h.pc[9:0];
        if (m_bc != '1) m_bc++;
        if (mis) begin
          e.mis = 1'b1;
          e.redir = rt ? rtgt : h.pc + 32'd4;
          if (m_mc != '1) m_mc++;
          mq.delete();
        end else begin
          void'(mq.pop_front());
        end
      end
      if (pv && !was_full && !mis) begin
        n.pc = pc; n.tk = pt; n.tgt = ptgt;
        mq.push_back(n);
      end
    end
    e.bc = m_bc; e.mc = m_mc; e.full = (mq.size() == DEPTH);
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("upd_valid", 32'(upd_valid_o), 32'(e.uv));
      check_eq("mispredict", 32'(mispredict_o), 32'(e.mis));
      check_eq("res_error", 32'(res_error_o), 32'(e.err));
      check_eq("full", 32'(full_o), 32'(e.full));
      check_eq("branch_cnt", 32'(branch_cnt_o), 32'(e.bc));
      check_eq("mispredict_cnt", 32'(mispredict_cnt_o), 32'(e.mc));
      if (e.uv) begin
        check_eq("upd_taken", 32'(upd_taken_o), 32'(e.ut));
        check_eq("upd_pc", 32'(upd_pc_lsb10_o), 32'(e.upc));
      end
      if (e.mis) check_eq("redirect_pc", redirect_pc_o, e.redir);
    end
  endtask

  task automatic enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    step(0, 1, pc, pt, tgt, 0, 0, 0, 0);
  endtask

  task automatic res(input logic rt, input logic [31:0] tgt);
    step(0, 0, 0, 0, 0, 1, rt, tgt, 0);
  endtask

  initial begin
    m_bc = '0; m_mc = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    enq(32'h100, 0, 0);
    res(0, 0);

    enq(32'h200, 0, 0); enq(32'h204, 0, 0); enq(32'h208, 0, 0);
    res(1, 32'h300);
    res(0, 0);

    enq(32'h3FC, 1, 32'h400);
    res(1, 32'h500);

    enq(32'hFFFF_FFFC, 1, 32'h10);
    res(0, 0);

    enq(32'h1000, 0, 0); enq(32'h1004, 0, 0); enq(32'h1008, 0, 0); enq(32'h100C, 0, 0);
    step(0, 1, 32'h2000, 0, 0, 1, 0, 0, 0);
    res(0, 0); res(0, 0); res(0, 0);
    res(0, 0);

    enq(32'h500, 0, 0); enq(32'h504, 0, 0); enq(32'h508, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h900, 1);
    res(0, 0);

    enq(32'h600, 0, 0); enq(32'h604, 0, 0);
    step(0, 1, 32'h608, 0, 0, 1, 0, 0, 0);
    step(1, 1, 32'h60C, 0, 0, 1, 0, 0, 0);
    res(0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc, tgt;
      pc  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      tgt = 32'h8000 + 32'($urandom_range(0, 1)) * 4;
      step(0, 1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)), tgt,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           32'h8000 + 32'($urandom_range(0, 1)) * 4,
           1'($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
